// File: rtl/cm_sketch_sched_pkg.sv
// Shared types and defaults for the count-min sketch front-end scheduler.
package cm_sketch_sched_pkg;

  // RUN: arbitrate traffic; QUERY: one-cycle flush pulse; DRAIN: wait for the flush to finish
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    QUERY = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_FLUSH_CYCLES = 4;
  localparam int DEF_ADDR_SIZE    = 22;

endpackage

// File: rtl/cm_sketch_sched_if.sv
// Requester and sketch-side handshake bundle for the scheduler.
interface cm_sketch_sched_if
  import cm_sketch_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         sk_valid;
  logic [ADDR_SIZE-1:0]         sk_addr;
  logic                         sk_ready;
  logic                         sk_query_en;

  // Environment side: drives requesters and the sketch's ready
  modport master (
    output req_valid, req_addr, sk_ready,
    input  req_ready, sk_valid, sk_addr, sk_query_en
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_addr, sk_ready,
    output req_ready, sk_valid, sk_addr, sk_query_en
  );
endinterface

// File: rtl/cm_sketch_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan NUM_REQ positions starting at the pointer; first hit is the winner
  always_comb begin
    logic [IDX_W:0]   v_sum;
    logic [IDX_W-1:0] v_j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    v_sum   = '0;
    v_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (v_sum >= (IDX_W+1)'(NUM_REQ)) v_sum = v_sum - (IDX_W+1)'(NUM_REQ);
      v_j = v_sum[IDX_W-1:0];
      if (!o_any && i_req[v_j]) begin
        o_any      = 1'b1;
        o_idx      = v_j;
        o_grant[v_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cm_sketch_sched.sv
// Front-end scheduler: round-robins requesters onto the sketch input and
// sequences query/flush epochs.
//
// state | meaning
// RUN   | grants flow to the output register; epoch timer runs
// QUERY | sk_query_en high; epoch count snapshotted and cleared
// DRAIN | FLUSH_CYCLES cycles with traffic blocked; query_done on the last
module cm_sketch_sched
  import cm_sketch_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int REQ_IDX_SIZE = $clog2(NUM_REQ),
  parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
  parameter int EPOCH_SIZE   = 32,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int STAT_SIZE    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cm_sketch_sched_if.slave      bus,
  input  logic [EPOCH_SIZE-1:0] epoch_len,
  input  logic                  query_req,
  output logic                  query_done,
  output logic [STAT_SIZE-1:0]  epoch_fwd_cnt,
  output logic [STAT_SIZE-1:0]  last_epoch_cnt
);

  localparam int DRAIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t                  r_state, w_state_nxt;
  logic [REQ_IDX_SIZE-1:0] r_rr_ptr;
  logic [EPOCH_SIZE-1:0]   r_timer;
  logic                    r_pending;
  logic [DRAIN_W-1:0]      r_drain_cnt;
  logic                    r_sk_valid;
  logic [ADDR_SIZE-1:0]    r_sk_addr;
  logic                    r_query_en;
  logic [STAT_SIZE-1:0]    r_fwd_cnt;
  logic [STAT_SIZE-1:0]    r_last_cnt;

  logic [NUM_REQ-1:0]      w_gnt_oh;
  logic [REQ_IDX_SIZE-1:0] w_idx;
  logic                    w_any;
  logic                    w_run;
  logic                    w_in_query;
  logic                    w_can_load;
  logic                    w_grant;
  logic                    w_xfer;
  logic                    w_expire;
  logic [ADDR_SIZE-1:0]    w_win_addr;
  logic [STAT_SIZE-1:0]    w_cnt_inc;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(REQ_IDX_SIZE)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_gnt_oh),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state: leave RUN only once the output register is empty or emptying
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (r_pending && (!r_sk_valid || bus.sk_ready)) w_state_nxt = QUERY;
      QUERY:   w_state_nxt = DRAIN;
      DRAIN:   if (r_drain_cnt == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // State decode; RUN is gated by rst so no ready leaks out while held in reset
  always_comb begin
    w_run      = 1'b0;
    w_in_query = 1'b0;
    query_done = 1'b0;
    case (r_state)
      RUN:     w_run = !rst;
      QUERY:   w_in_query = 1'b1;
      DRAIN:   query_done = (r_drain_cnt == '0);
      default: ;
    endcase
  end

  assign w_can_load = w_run && !r_pending && (!r_sk_valid || bus.sk_ready);
  assign w_grant    = w_can_load && w_any;
  assign w_xfer     = r_sk_valid && bus.sk_ready;
  assign w_expire   = (r_state == RUN) && (epoch_len != '0) &&
                      (r_timer == epoch_len - EPOCH_SIZE'(1));
  assign w_cnt_inc  = (w_xfer && !(&r_fwd_cnt)) ? r_fwd_cnt + STAT_SIZE'(1) : r_fwd_cnt;

  assign bus.req_ready   = w_can_load ? w_gnt_oh : '0;
  assign bus.sk_valid    = r_sk_valid;
  assign bus.sk_addr     = r_sk_addr;
  assign bus.sk_query_en = r_query_en;
  assign epoch_fwd_cnt   = r_fwd_cnt;
  assign last_epoch_cnt  = r_last_cnt;

  // Select the winning requester's address
  always_comb begin
    w_win_addr = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_idx == REQ_IDX_SIZE'(k)) w_win_addr = bus.req_addr[k*ADDR_SIZE +: ADDR_SIZE];
  end

  // Output register and round-robin pointer; a grant overrides the drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sk_valid <= 1'b0;
      r_sk_addr  <= '0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_sk_valid <= 1'b1;
      r_sk_addr  <= w_win_addr;
      r_rr_ptr   <= (w_idx == REQ_IDX_SIZE'(NUM_REQ-1)) ? '0 : w_idx + REQ_IDX_SIZE'(1);
    end else if (w_xfer) begin
      r_sk_valid <= 1'b0;
    end
  end

  // Epoch timer counts RUN cycles and restarts at each query
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timer <= '0;
    else case (r_state)
      RUN:     r_timer <= r_timer + EPOCH_SIZE'(1);
      QUERY:   r_timer <= '0;
      default: ;
    endcase
  end

  // Query request latch; a request arriving during QUERY survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_pending <= 1'b0;
    else if (w_in_query) r_pending <= query_req;
    else                 r_pending <= r_pending | query_req | w_expire;
  end

  // Flush wait as a down-counter; terminal count of zero ends DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_drain_cnt <= '0;
    else if (w_in_query)                           r_drain_cnt <= DRAIN_W'(FLUSH_CYCLES-1);
    else if (r_state == DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
  end

  // Registered query pulse, high exactly while in QUERY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_query_en <= 1'b0;
    else     r_query_en <= (w_state_nxt == QUERY);
  end

  // Per-epoch forwarded count; the snapshot includes a transfer in the QUERY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_cnt  <= '0;
      r_last_cnt <= '0;
    end else if (w_in_query) begin
      r_last_cnt <= w_cnt_inc;
      r_fwd_cnt  <= '0;
    end else begin
      r_fwd_cnt  <= w_cnt_inc;
    end
  end

endmodule

// File: tb/tb_cm_sketch_sched.sv
// Directed plus randomized bench for cm_sketch_sched with an epoch-level reference model.
module tb_cm_sketch_sched;
  import cm_sketch_sched_pkg::*;

  localparam int NR = 2;
  localparam int AW = 22;
  localparam int FC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] epoch_len;
  logic        query_req;
  logic        query_done;
  logic [31:0] epoch_fwd_cnt;
  logic [31:0] last_epoch_cnt;

  cm_sketch_sched_if #(.NUM_REQ(NR), .ADDR_SIZE(AW)) bus ();

  cm_sketch_sched #(
    .NUM_REQ(NR), .ADDR_SIZE(AW), .EPOCH_SIZE(32), .FLUSH_CYCLES(FC), .STAT_SIZE(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .epoch_len      (epoch_len),
    .query_req      (query_req),
    .query_done     (query_done),
    .epoch_fwd_cnt  (epoch_fwd_cnt),
    .last_epoch_cnt (last_epoch_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 = traffic, 1 = query pulse, 2 = flush wait
  int          m_phase, m_left, m_ptr, m_gnt;
  bit          m_pend, m_skv;
  logic [21:0] m_ska;
  logic [31:0] m_timer, m_cnt, m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_left = 0; m_ptr = 0; m_gnt = -1;
    m_pend = 0; m_skv = 0; m_ska = '0;
    m_timer = 0; m_cnt = 0; m_last = 0;
  endtask

  task automatic set_addr(input int i, input logic [21:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  // Compare every output with the model for this cycle, then advance one clock
  task automatic step();
    int   win, j;
    logic [1:0]  exp_rr;
    logic [31:0] nxt_cnt;
    bit   can, xfer, expire;
    #1;
    can = (m_phase == 0) && !m_pend && (!m_skv || bus.sk_ready);
    win = -1;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (win < 0 && bus.req_valid[j]) win = j;
    end
    exp_rr = (can && win >= 0) ? (2'b01 << win) : 2'b00;
    chk("req_ready", bus.req_ready, exp_rr);
    chk("sk_valid", bus.sk_valid, m_skv);
    chk("sk_addr", bus.sk_addr, m_ska);
    chk("sk_query_en", bus.sk_query_en, m_phase == 1);
    chk("query_done", query_done, (m_phase == 2) && (m_left == 1));
    chk("epoch_fwd_cnt", epoch_fwd_cnt, m_cnt);
    chk("last_epoch_cnt", last_epoch_cnt, m_last);

    m_gnt   = (can && win >= 0) ? win : -1;
    xfer    = m_skv && bus.sk_ready;
    nxt_cnt = (xfer && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
    expire  = (m_phase == 0) && (epoch_len != 0) && (m_timer == epoch_len - 1);
    case (m_phase)
      0: begin
        m_timer = m_timer + 1;
        if (m_pend && (!m_skv || bus.sk_ready)) m_phase = 1;
        m_pend = m_pend | query_req | expire;
        m_cnt  = nxt_cnt;
      end
      1: begin
        m_last = nxt_cnt; m_cnt = 0; m_timer = 0;
        m_pend = query_req; m_phase = 2; m_left = FC;
      end
      default: begin
        m_cnt  = nxt_cnt;
        m_pend = m_pend | query_req;
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    if (m_gnt >= 0) begin
      m_skv = 1;
      m_ska = bus.req_addr[m_gnt*AW +: AW];
      m_ptr = (m_gnt + 1) % NR;
    end else if (xfer) begin
      m_skv = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [21:0] seq [6];
    int acc0, acc1, qc, dc, found;
    seq = '{22'h100, 22'h200, 22'h101, 22'h201, 22'h102, 22'h202};
    rst = 1'b1; epoch_len = 0; query_req = 0;
    bus.req_valid = '0; bus.req_addr = '0; bus.sk_ready = 1'b0;
    m_reset();
    #2;
    chk("rst_sk_valid", bus.sk_valid, 0);
    chk("rst_sk_addr", bus.sk_addr, 0);
    chk("rst_query_en", bus.sk_query_en, 0);
    chk("rst_query_done", query_done, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_fwd", epoch_fwd_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two streams alternate
    acc0 = 0; acc1 = 0; bus.sk_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.req_valid = (k < 6) ? 2'b11 : 2'b00;
      set_addr(0, 22'h100 + 22'(acc0));
      set_addr(1, 22'h200 + 22'(acc1));
      if (k >= 1) chk("alt_addr", bus.sk_addr, seq[k-1]);
      step();
      if (m_gnt == 0) acc0++;
      if (m_gnt == 1) acc1++;
    end
    chk("fwd_after_6", epoch_fwd_cnt, 6);

    // Back-pressure holds the output register
    bus.req_valid = 2'b01; set_addr(0, 22'h3AB); set_addr(1, 22'h055);
    step();
    bus.req_valid = 2'b10; bus.sk_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_addr", bus.sk_addr, 22'h3AB);
      #1 chk("stall_rr", bus.req_ready, 2'b00);
      step();
    end
    bus.sk_ready = 1'b1;
    #1 chk("release_rr", bus.req_ready, 2'b10);
    step();
    chk("release_addr", bus.sk_addr, 22'h055);
    chk("release_valid", bus.sk_valid, 1);

    // Epoch timer of 10 with requester 0 streaming
    epoch_len = 10; bus.req_valid = 2'b01; bus.sk_ready = 1'b1;
    do_reset();
    acc0 = 0; qc = -1;
    for (int c = 0; c < 40 && qc < 0; c++) begin
      set_addr(0, 22'h400 + 22'(acc0));
      if (bus.sk_query_en) qc = c;
      step();
      if (m_gnt == 0) acc0++;
    end
    chk("epoch_qen_cycle", qc, 11);
    chk("epoch_last_cnt", last_epoch_cnt, 10);
    dc = -1;
    for (int c = qc + 1; c < qc + 12 && dc < 0; c++) begin
      if (query_done) dc = c;
      step();
    end
    chk("epoch_done_cycle", dc, 15);
    epoch_len = 0;
    #1 chk("resume_rr", bus.req_ready, 2'b01);
    step();

    // Software query while the output register is stalled
    chk("stall_q_valid", bus.sk_valid, 1);
    bus.sk_ready = 1'b0; query_req = 1'b1;
    step();
    query_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("no_qen_stall", bus.sk_query_en, 0);
      step();
    end
    bus.sk_ready = 1'b1;
    chk("no_qen_xfer", bus.sk_query_en, 0);
    step();
    chk("qen_after_xfer", bus.sk_query_en, 1);
    step();

    // Query request during DRAIN is serviced right after query_done
    step();
    query_req = 1'b1;
    step();
    query_req = 1'b0;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      if (query_done) found = 1;
      step();
    end
    chk("drain_done_seen", found, 1);
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      if (bus.sk_query_en) found = 1;
      step();
    end
    chk("second_qen_seen", found, 1);
    chk("second_last_zero", last_epoch_cnt, 0);

    // Asynchronous reset in the middle of DRAIN
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_query_done", query_done, 0);
    chk("arst_sk_valid", bus.sk_valid, 0);
    chk("arst_sk_addr", bus.sk_addr, 0);
    chk("arst_query_en", bus.sk_query_en, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_last", last_epoch_cnt, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    #1 chk("post_rst_rr", bus.req_ready, 2'b01);
    for (int k = 0; k < 8; k++) step();

    // Randomized traffic against the model, including epoch_len = 1
    for (int t = 0; t < 3; t++) begin
      epoch_len = (t == 0) ? 32'd1 : 32'($urandom_range(2, 30));
      do_reset();
      for (int c = 0; c < 300; c++) begin
        bus.req_valid = 2'($urandom);
        set_addr(0, 22'($urandom));
        set_addr(1, 22'($urandom));
        bus.sk_ready  = ($urandom_range(0, 3) != 0);
        query_req     = ($urandom_range(0, 29) == 0);
        step();
      end
    end
    query_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
